// File: rtl/wall_clear_detector_n.sv
// -----------------------------------------------------------------------------
// wall_clear_detector_n
//
// Purpose:
//   N-player brick-wall-cleared detector. For each player the row-group empty
//   flags are ANDed into a wall_empty indication. A ball/paddle hit (falling
//   edge of BP_HIT_N) that finds the wall empty sets that player's cleared
//   latch. The rising edge of the latch loads a retriggerable down-counter
//   that drives a fixed-length FPD (rack done) pulse. A per-player saturating
//   counter tracks walls cleared during the current game.
//
// Ports:
//   CLK_DRV       in   1             system clock, all state on rising edge
//   RESET         in   1             synchronous active-high reset
//   ROW_EMPTY     in   PLAYERS*ROWS  row-group empty flags, player p at [p*ROWS +: ROWS]
//   BP_HIT_N      in   1             ball/paddle hit, active low, synchronous
//   START_GAME_N  in   1             active-low new-game clear (level)
//   FPD           out  PLAYERS       rack-done pulse per player, active high
//   FPD_N         out  PLAYERS       complement of FPD
//   CLEAR_CNT     out  PLAYERS*CW    walls cleared this game, player p at [p*CW +: CW]
//
// Per-player cleared latch:
//   latch | meaning
//   ------+-------------------------------------------------------------
//     0   | armed: next hit with an empty wall counts as a cleared rack
//     1   | rack already counted; held until new game (or refill if REARM)
// -----------------------------------------------------------------------------
module wall_clear_detector_n #(
  parameter int PLAYERS      = 2,
  parameter int ROWS         = 3,
  parameter int PULSE_COUNTS = 934679,
  parameter int REARM        = 0,
  parameter int CW           = 4
) (
  input  logic                    CLK_DRV,
  input  logic                    RESET,
  input  logic [PLAYERS*ROWS-1:0] ROW_EMPTY,
  input  logic                    BP_HIT_N,
  input  logic                    START_GAME_N,
  output logic [PLAYERS-1:0]      FPD,
  output logic [PLAYERS-1:0]      FPD_N,
  output logic [PLAYERS*CW-1:0]   CLEAR_CNT
);

  localparam int            TW      = $clog2(PULSE_COUNTS + 1);
  localparam logic [TW-1:0] T_LOAD  = TW'(PULSE_COUNTS);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic          REARM_EN = (REARM != 0);

  // Hit edge detector. Resetting the history to 1 means a BP_HIT_N that is
  // already low at reset release is still seen as a single falling edge,
  // but never as more than one.
  logic hit_n_q;
  logic hit;

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      hit_n_q <= 1'b1;
    end else begin
      hit_n_q <= BP_HIT_N;
    end
  end

  assign hit = hit_n_q & ~BP_HIT_N;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [ROWS-1:0] rows;
    logic            wall_empty;
    logic            latch_q;
    logic            set_evt;
    logic            rearm_clr;
    logic [TW-1:0]   t_q;
    logic [TW-1:0]   t_nxt;
    logic            fpd_q;
    logic [CW-1:0]   cnt_q;

    assign rows       = ROW_EMPTY[p*ROWS +: ROWS];
    assign wall_empty = &rows;

    // Set is only possible from the armed state, so set_evt is exactly the
    // latch's rising edge. A new game holds the latch clear.
    assign set_evt   = hit & wall_empty & ~latch_q & START_GAME_N;
    assign rearm_clr = REARM_EN & ~wall_empty & latch_q;

    // Retriggerable one-shot: a set event always reloads, even mid-pulse.
    always_comb begin
      t_nxt = t_q;
      if (set_evt) begin
        t_nxt = T_LOAD;
      end else if (t_q != '0) begin
        t_nxt = t_q - T_ONE;
      end
    end

    always_ff @(posedge CLK_DRV) begin
      if (RESET) begin
        latch_q <= 1'b0;
        t_q     <= '0;
        fpd_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        t_q   <= t_nxt;
        // Registered from the next timer value so FPD rises the cycle after
        // the hit is sampled and stays high exactly PULSE_COUNTS cycles.
        fpd_q <= (t_nxt != '0);

        if (!START_GAME_N) begin
          latch_q <= 1'b0;
        end else if (set_evt) begin
          latch_q <= 1'b1;
        end else if (rearm_clr) begin
          latch_q <= 1'b0;
        end

        // New game clears the count but leaves a running pulse alone.
        if (!START_GAME_N) begin
          cnt_q <= '0;
        end else if (set_evt && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end

    assign FPD[p]              = fpd_q;
    assign FPD_N[p]            = ~fpd_q;
    assign CLEAR_CNT[p*CW +: CW] = cnt_q;
  end

endmodule

// File: tb/tb_wall_clear_detector_n.sv
module tb_wall_clear_detector_n;
  localparam int PC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] rows;
  logic       bp_n;
  logic       start_n;

  logic [1:0] fpd0, fpdn0, fpd1, fpdn1;
  logic [7:0] cc0;
  logic [3:0] cc1;

  always #5 clk = ~clk;

  // Instance 0: single set per game, 4-bit count.
  wall_clear_detector_n #(.PLAYERS(2), .ROWS(3), .PULSE_COUNTS(PC), .REARM(0), .CW(4)) dut0 (
    .CLK_DRV(clk), .RESET(rst), .ROW_EMPTY(rows), .BP_HIT_N(bp_n),
    .START_GAME_N(start_n), .FPD(fpd0), .FPD_N(fpdn0), .CLEAR_CNT(cc0));

  // Instance 1: re-arming, 2-bit count.
  wall_clear_detector_n #(.PLAYERS(2), .ROWS(3), .PULSE_COUNTS(PC), .REARM(1), .CW(2)) dut1 (
    .CLK_DRV(clk), .RESET(rst), .ROW_EMPTY(rows), .BP_HIT_N(bp_n),
    .START_GAME_N(start_n), .FPD(fpd1), .FPD_N(fpdn1), .CLEAR_CNT(cc1));

  // Reference model: each player remembers whether its rack has been counted,
  // the clock edge of its most recent fire, and its count. FPD is expected
  // high during the PC edges starting at the fire edge.
  int cyc = 0;
  bit started = 0;
  bit m_prev_n = 1;
  int m_armed [2][2];
  int m_fire  [2][2];
  int m_cnt   [2][2];

  always @(posedge clk) begin
    bit hit;
    bit we;
    int cmax;
    cyc = cyc + 1;
    if (rst) begin
      started  = 1;
      m_prev_n = 1;
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          m_armed[i][p] = 0;
          m_cnt[i][p]   = 0;
          m_fire[i][p]  = -1000;
        end
    end else begin
      hit = m_prev_n && !bp_n;
      for (int i = 0; i < 2; i++) begin
        cmax = (i == 0) ? 15 : 3;
        for (int p = 0; p < 2; p++) begin
          we = (rows[p*3 +: 3] == 3'b111);
          if (!start_n) begin
            m_armed[i][p] = 0;
            m_cnt[i][p]   = 0;
          end else if (hit && we && m_armed[i][p] == 0) begin
            m_armed[i][p] = 1;
            m_fire[i][p]  = cyc;
            if (m_cnt[i][p] < cmax) m_cnt[i][p] = m_cnt[i][p] + 1;
          end else if (i == 1 && !we && m_armed[i][p] != 0) begin
            m_armed[i][p] = 0;
          end
        end
      end
      m_prev_n = bp_n;
    end
  end

  function automatic int exp_fpd(int i, int p);
    return (cyc >= m_fire[i][p] && (cyc - m_fire[i][p]) < PC) ? 1 : 0;
  endfunction

  int tests = 0;
  int fails = 0;
  int run_len  [2][2];
  int last_run [2][2];
  int tot      [2][2];

  task automatic chk(string name, int act, int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_hit();
    bp_n = 1'b0;
    step(1);
    bp_n = 1'b1;
    step(1);
  endtask

  initial begin
    int base;
    rst = 1'b1; start_n = 1'b1; bp_n = 1'b0; rows = 6'b0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        run_len[i][p] = 0; last_run[i][p] = 0; tot[i][p] = 0;
      end

    // Per-cycle comparison against the model, plus pulse-length bookkeeping.
    fork
      forever begin
        @(negedge clk);
        if (started) begin
          for (int p = 0; p < 2; p++) begin
            int e0, e1;
            e0 = exp_fpd(0, p);
            e1 = exp_fpd(1, p);
            chk($sformatf("dut0.fpd[%0d]", p), int'(fpd0[p]), e0);
            chk($sformatf("dut0.fpd_n[%0d]", p), int'(fpdn0[p]), 1 - e0);
            chk($sformatf("dut0.clear_cnt[%0d]", p), int'(cc0[p*4 +: 4]), m_cnt[0][p]);
            chk($sformatf("dut1.fpd[%0d]", p), int'(fpd1[p]), e1);
            chk($sformatf("dut1.fpd_n[%0d]", p), int'(fpdn1[p]), 1 - e1);
            chk($sformatf("dut1.clear_cnt[%0d]", p), int'(cc1[p*2 +: 2]), m_cnt[1][p]);
            for (int i = 0; i < 2; i++) begin
              logic f;
              f = (i == 0) ? fpd0[p] : fpd1[p];
              if (f === 1'b1) begin
                run_len[i][p] = run_len[i][p] + 1;
                tot[i][p]     = tot[i][p] + 1;
              end else if (run_len[i][p] != 0) begin
                last_run[i][p] = run_len[i][p];
                run_len[i][p]  = 0;
              end
            end
          end
        end
      end
    join_none

    // 1: reset, idle, stale low BP_HIT_N with a non-empty wall.
    step(2);
    rst = 1'b0;
    step(4);
    chk("reset fpd0", int'(fpd0), 0);
    chk("reset fpd_n0", int'(fpdn0), 3);
    chk("reset cnt0", int'(cc0), 0);
    chk("reset fpd1", int'(fpd1), 0);
    chk("reset cnt1", int'(cc1), 0);
    bp_n = 1'b1;
    step(2);

    // 2: player 0 wall empty, hit -> 8-cycle pulse; second hit ignored.
    rows = 6'b000_111;
    step(1);
    do_hit();
    step(12);
    chk("p0 pulse length", last_run[0][0], 8);
    chk("p0 count after first rack", int'(cc0[3:0]), 1);
    chk("p1 quiet", tot[0][1], 0);
    do_hit();
    step(12);
    chk("p0 second hit no pulse", tot[0][0], 8);
    chk("p0 count held", int'(cc0[3:0]), 1);

    // 3: player 1 partial wall ignored, full wall fires.
    rows = 6'b101_111;
    step(1);
    do_hit();
    step(12);
    chk("p1 partial wall", tot[0][1], 0);
    rows = 6'b111_111;
    step(1);
    do_hit();
    step(12);
    chk("p1 pulse length", last_run[0][1], 8);
    chk("p1 count", int'(cc0[7:4]), 1);

    // 4: new game coincident with hit blocks set; new game mid-pulse does not abort.
    start_n = 1'b0;
    bp_n = 1'b0;
    step(1);
    start_n = 1'b1;
    bp_n = 1'b1;
    step(12);
    chk("start blocks set", tot[0][0], 8);
    chk("start clears count", int'(cc0[3:0]), 0);
    bp_n = 1'b0;
    step(1);
    bp_n = 1'b1;
    step(3);
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    step(10);
    chk("pulse survives start", last_run[0][0], 8);
    chk("count cleared mid-pulse", int'(cc0[3:0]), 0);
    do_hit();
    step(12);
    chk("fires again after start", tot[0][0], 24);
    chk("count after refire", int'(cc0[3:0]), 1);

    // 5: re-arm, five racks, 2-bit count saturates; retrigger stretches pulse.
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    base = tot[1][0];
    for (int k = 0; k < 5; k++) begin
      rows[2:0] = 3'b000;
      step(2);
      rows[2:0] = 3'b111;
      step(1);
      do_hit();
      step(10);
    end
    chk("rearm five pulses", tot[1][0] - base, 40);
    chk("rearm count saturates", int'(cc1[1:0]), 3);
    rows[2:0] = 3'b000;
    step(1);
    rows[2:0] = 3'b111;
    step(1);
    bp_n = 1'b0;
    step(1);
    bp_n = 1'b1;
    rows[2:0] = 3'b000;
    step(1);
    rows[2:0] = 3'b111;
    step(1);
    bp_n = 1'b0;
    step(1);
    bp_n = 1'b1;
    step(15);
    chk("retrigger stretched pulse", last_run[1][0], 11);

    // 6: reset mid-pulse aborts it.
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    step(1);
    bp_n = 1'b0;
    step(1);
    bp_n = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    chk("reset mid-pulse fpd0", int'(fpd0), 0);
    chk("reset mid-pulse fpd1", int'(fpd1), 0);
    chk("reset mid-pulse cnt0", int'(cc0), 0);
    chk("reset mid-pulse cnt1", int'(cc1), 0);
    rst = 1'b0;
    step(2);
    chk("aborted pulse length", last_run[0][0], 3);

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start_n = !($urandom_range(0, 59) == 0);
      bp_n    = ($urandom_range(0, 2) != 0);
      for (int p = 0; p < 2; p++)
        rows[p*3 +: 3] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
